// File: rtl/rob_commit_pkg.sv
// Shared definitions for the reorder buffer commit block.
// Covers opcodes, ROB geometry, the entry layout and the FSM states.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 8;
    localparam int TAG_W     = 3;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNEQ  = 4'b0111;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic [3:0]  func;
        logic [3:0]  rd;
        logic [15:0] value;
        logic [7:0]  addr;
    } rob_entry_t;

    typedef enum logic {ST_RUN, ST_FLUSH} rob_state_e;

    typedef enum logic [1:0] {CK_REG, CK_STORE, CK_BRANCH, CK_NONE} commit_kind_e;

    // Opcodes 1000-1111 retire without touching any commit port.
    function automatic commit_kind_e classify(input logic [3:0] func);
        case (func)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_LOAD: classify = CK_REG;
            OP_STORE:                                classify = CK_STORE;
            OP_BEQ, OP_BNEQ:                         classify = CK_BRANCH;
            default:                                 classify = CK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rob_commit.sv
// 8-entry reorder buffer: in-order allocation, out-of-order CDB completion,
// in-order single-entry commit with taken-branch flush.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    input  logic [3:0]        alloc_func,
    input  logic [3:0]        alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_idx,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_idx,
    input  logic [15:0]       cdb_data,
    input  logic [7:0]        cdb_addr,
    output logic              rf_we,
    output logic [3:0]        rf_waddr,
    output logic [15:0]       rf_wdata,
    output logic [TAG_W-1:0]  rf_wtag,
    output logic              mem_we,
    output logic [7:0]        mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              flush,
    output logic [3:0]        flush_target,
    output logic [3:0]        count,
    output logic              empty
);

    rob_entry_t [ROB_DEPTH-1:0] rob;
    logic [TAG_W-1:0]           head;
    logic [TAG_W-1:0]           tail;
    logic [3:0]                 count_q;
    rob_state_e                 state;

    rob_entry_t   head_entry;
    commit_kind_e head_kind;
    logic         alloc_fire;
    logic         cdb_fire;
    logic         commit_fire;
    logic         taken_flush;

    always_comb begin
        alloc_ready = (count_q < 4'(DEPTH)) && (state == ST_RUN);
        alloc_idx   = tail;
        count       = count_q;
        empty       = (count_q == 4'd0);

        head_entry  = rob[head];
        head_kind   = classify(head_entry.func);
        alloc_fire  = alloc_valid && alloc_ready;
        cdb_fire    = cdb_valid && (state == ST_RUN) && rob[cdb_idx].busy;
        commit_fire = head_entry.busy && head_entry.ready;
        taken_flush = commit_fire && (head_kind == CK_BRANCH) && head_entry.value[0];
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rob[i].busy  <= 1'b0;
                rob[i].ready <= 1'b0;
            end
            head         <= '0;
            tail         <= '0;
            count_q      <= '0;
            state        <= ST_RUN;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            rf_wtag      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            flush        <= 1'b0;
            flush_target <= '0;
        end else begin
            rf_we  <= 1'b0;
            mem_we <= 1'b0;
            flush  <= 1'b0;
            if (state == ST_FLUSH)
                state <= ST_RUN;

            if (taken_flush) begin
                // Everything younger than the mispredicted branch is discarded,
                // including any allocation offered at this same edge.
                for (int i = 0; i < ROB_DEPTH; i++)
                    rob[i].busy <= 1'b0;
                head         <= '0;
                tail         <= '0;
                count_q      <= '0;
                state        <= ST_FLUSH;
                flush        <= 1'b1;
                flush_target <= head_entry.rd;
            end else begin
                if (alloc_fire) begin
                    rob[tail].busy  <= 1'b1;
                    rob[tail].ready <= 1'b0;
                    rob[tail].func  <= alloc_func;
                    rob[tail].rd    <= alloc_rd;
                    tail            <= tail + 1'b1;
                end
                if (cdb_fire) begin
                    rob[cdb_idx].ready <= 1'b1;
                    rob[cdb_idx].value <= cdb_data;
                    rob[cdb_idx].addr  <= cdb_addr;
                end
                if (commit_fire) begin
                    rob[head].busy <= 1'b0;
                    head           <= head + 1'b1;
                    case (head_kind)
                        CK_REG: begin
                            rf_we    <= 1'b1;
                            rf_waddr <= head_entry.rd;
                            rf_wdata <= head_entry.value;
                            rf_wtag  <= head;
                        end
                        CK_STORE: begin
                            mem_we    <= 1'b1;
                            mem_addr  <= head_entry.addr;
                            mem_wdata <= head_entry.value;
                        end
                        default: ;
                    endcase
                end
                count_q <= count_q + {3'b000, alloc_fire} - {3'b000, commit_fire};
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit with hand-computed expectations.
module tb_rob_commit;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        alloc_valid;
    logic [3:0]  alloc_func;
    logic [3:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_idx;
    logic        cdb_valid;
    logic [2:0]  cdb_idx;
    logic [15:0] cdb_data;
    logic [7:0]  cdb_addr;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [2:0]  rf_wtag;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        flush;
    logic [3:0]  flush_target;
    logic [3:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    rob_commit dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_func(alloc_func), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wtag(rf_wtag),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .flush(flush), .flush_target(flush_target),
        .count(count), .empty(empty)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] f, input logic [3:0] r);
        alloc_valid = 1'b1;
        alloc_func  = f;
        alloc_rd    = r;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_cdb(input logic [2:0] idx, input logic [15:0] d, input logic [7:0] a);
        cdb_valid = 1'b1;
        cdb_idx   = idx;
        cdb_data  = d;
        cdb_addr  = a;
        step();
        cdb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_func = '0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_idx = '0; cdb_data = '0; cdb_addr = '0;
        step();
        step();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_alloc_idx", alloc_idx, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_flush", flush, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        rst = 1'b0;

        // Single add round trip
        check("add_idx_before", alloc_idx, 0);
        do_alloc(4'b0000, 4'd5);
        check("add_count", count, 1);
        check("add_empty", empty, 0);
        do_cdb(3'd0, 16'h1234, 8'h00);
        check("add_no_early_commit", rf_we, 0);
        step();
        check("add_rf_we", rf_we, 1);
        check("add_rf_waddr", rf_waddr, 5);
        check("add_rf_wdata", rf_wdata, 16'h1234);
        check("add_rf_wtag", rf_wtag, 0);
        check("add_count_after", count, 0);
        step();
        check("add_rf_we_pulse", rf_we, 0);

        // Out-of-order completion, in-order commit
        do_reset();
        do_alloc(4'b0001, 4'd1);
        do_alloc(4'b0010, 4'd2);
        do_alloc(4'b0100, 4'd3);
        check("ooo_count", count, 3);
        do_cdb(3'd2, 16'h0022, 8'h00);
        do_cdb(3'd1, 16'h0011, 8'h00);
        check("ooo_no_commit_yet", rf_we, 0);
        do_cdb(3'd0, 16'h0000, 8'h00);
        check("ooo_no_commit_at_cdb0", rf_we, 0);
        step();
        check("ooo_c0_we", rf_we, 1);
        check("ooo_c0_tag", rf_wtag, 0);
        check("ooo_c0_waddr", rf_waddr, 1);
        step();
        check("ooo_c1_we", rf_we, 1);
        check("ooo_c1_tag", rf_wtag, 1);
        check("ooo_c1_wdata", rf_wdata, 16'h0011);
        step();
        check("ooo_c2_we", rf_we, 1);
        check("ooo_c2_tag", rf_wtag, 2);
        check("ooo_c2_wdata", rf_wdata, 16'h0022);
        check("ooo_count_end", count, 0);
        step();
        check("ooo_done", rf_we, 0);

        // Full ROB, ignored alloc, simultaneous alloc+commit, tail wrap
        do_reset();
        for (int i = 0; i < 8; i++) begin
            check("fill_idx", alloc_idx, i);
            do_alloc(4'b0000, 4'(i));
        end
        check("full_count", count, 8);
        check("full_ready", alloc_ready, 0);
        check("full_idx_wrap", alloc_idx, 0);
        do_alloc(4'b0000, 4'hF);
        check("ninth_ignored_count", count, 8);
        check("ninth_ignored_idx", alloc_idx, 0);
        do_cdb(3'd0, 16'h00A0, 8'h00);
        do_cdb(3'd1, 16'h00A1, 8'h00);
        check("full_c0_tag", rf_wtag, 0);
        check("full_c0_count", count, 7);
        check("full_c0_ready", alloc_ready, 1);
        check("full_c0_idx", alloc_idx, 0);
        do_alloc(4'b0000, 4'hE);
        check("simul_c1_tag", rf_wtag, 1);
        check("simul_count", count, 7);
        check("simul_idx", alloc_idx, 1);
        do_alloc(4'b0000, 4'hD);
        check("refill_count", count, 8);
        check("refill_ready", alloc_ready, 0);

        // Store commit
        do_reset();
        do_alloc(4'b0101, 4'd0);
        do_cdb(3'd0, 16'hBEEF, 8'h3C);
        step();
        check("st_mem_we", mem_we, 1);
        check("st_mem_addr", mem_addr, 8'h3C);
        check("st_mem_wdata", mem_wdata, 16'hBEEF);
        check("st_rf_we", rf_we, 0);

        // Not-taken branch and no-op opcode retire silently
        do_reset();
        do_alloc(4'b0111, 4'd3);
        do_alloc(4'b1010, 4'd4);
        do_cdb(3'd0, 16'h0000, 8'h00);
        do_cdb(3'd1, 16'hFFFF, 8'hFF);
        check("nt_flush", flush, 0);
        check("nt_rf_we", rf_we, 0);
        check("nt_count", count, 1);
        step();
        check("nop_rf_we", rf_we, 0);
        check("nop_mem_we", mem_we, 0);
        check("nop_count", count, 0);

        // Taken branch flush
        do_reset();
        do_alloc(4'b0110, 4'hA);
        do_alloc(4'b0000, 4'd1);
        do_alloc(4'b0000, 4'd2);
        do_alloc(4'b0000, 4'd3);
        do_cdb(3'd0, 16'h0001, 8'h00);
        cdb_valid = 1'b1; cdb_idx = 3'd1; cdb_data = 16'h5555;
        step();
        cdb_valid = 1'b0;
        check("br_flush", flush, 1);
        check("br_target", flush_target, 4'hA);
        check("br_count", count, 0);
        check("br_empty", empty, 1);
        check("br_alloc_ready", alloc_ready, 0);
        check("br_rf_we", rf_we, 0);
        cdb_valid = 1'b1; cdb_idx = 3'd2; cdb_data = 16'h6666;
        alloc_valid = 1'b1; alloc_func = 4'b0000; alloc_rd = 4'd9;
        step();
        cdb_valid = 1'b0; alloc_valid = 1'b0;
        check("br_flush_pulse", flush, 0);
        check("br_alloc_ignored", count, 0);
        check("br_ready_again", alloc_ready, 1);
        check("br_idx_zero", alloc_idx, 0);
        do_alloc(4'b0000, 4'd7);
        do_cdb(3'd1, 16'h7777, 8'h00);
        step();
        check("br_stale_cdb_rf_we", rf_we, 0);
        check("br_stale_cdb_count", count, 1);

        // Reset with four ready entries
        do_reset();
        for (int i = 0; i < 4; i++) do_alloc(4'b0000, 4'(i));
        do_cdb(3'd3, 16'h0003, 8'h00);
        do_cdb(3'd2, 16'h0002, 8'h00);
        do_cdb(3'd1, 16'h0001, 8'h00);
        do_cdb(3'd0, 16'h0000, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_rf_we", rf_we, 0);
        check("mrst_count", count, 0);
        check("mrst_empty", empty, 1);
        step();
        check("mrst_rf_we_after", rf_we, 0);
        check("mrst_mem_we_after", mem_we, 0);
        check("mrst_count_after", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
